// File: rtl/dly_stretch_bank_if.sv
// rtl/dly_stretch_bank_if.sv - trigger, config and pulse bundle for dly_stretch_bank
// Purpose: groups the per-channel trigger inputs, configuration fields and pulse
//          outputs of the delay-and-stretch bank.
// Signals: din (NCH), cfg_dly (NCH*DW), cfg_wid (NCH*WW), cfg_retrig (NCH) driven by master;
//          dout, busy, drop (NCH each) driven by slave; veto (1) driven by master
//          only when DLY_VETO_EN is defined.
// Modports: master (trigger/config source), slave (the delay bank).
interface dly_stretch_bank_if #(
    parameter int NCH = 8,
    parameter int DW  = 4,
    parameter int WW  = 4
);
    logic [NCH-1:0]    din;
    logic [NCH*DW-1:0] cfg_dly;
    logic [NCH*WW-1:0] cfg_wid;
    logic [NCH-1:0]    cfg_retrig;
    logic [NCH-1:0]    dout;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    drop;
`ifdef DLY_VETO_EN
    logic              veto;

    modport master (output din, cfg_dly, cfg_wid, cfg_retrig, veto,
                    input  dout, busy, drop);
    modport slave  (input  din, cfg_dly, cfg_wid, cfg_retrig, veto,
                    output dout, busy, drop);
`else
    modport master (output din, cfg_dly, cfg_wid, cfg_retrig,
                    input  dout, busy, drop);
    modport slave  (input  din, cfg_dly, cfg_wid, cfg_retrig,
                    output dout, busy, drop);
`endif
endinterface

// File: rtl/dly_stretch_bank.sv
// rtl/dly_stretch_bank.sv - multi-channel programmable delay-and-stretch line
// Purpose: per channel, synchronise the raw trigger, detect its rising edge, wait a
//          programmable delay, then emit a pulse of programmable width. Optional
//          retrigger extension and drop reporting.
// Ports:   clk   - system clock, posedge
//          rst_n - asynchronous active-low reset, release synchronised internally
//          bus   - dly_stretch_bank_if.slave: din/cfg_dly/cfg_wid/cfg_retrig in,
//                  dout/busy/drop out (all registered)
// Option:  DLY_VETO_EN - adds bus.veto; edges detected while veto=1 are discarded silently.
module dly_stretch_bank #(
    parameter int NCH  = 8,
    parameter int DW   = 4,
    parameter int WW   = 4,
    parameter int SYNC = 2
) (
    input logic               clk,
    input logic               rst_n,
    dly_stretch_bank_if.slave bus
);
    localparam int CW  = (DW > WW) ? DW : WW;
    localparam int WCW = $clog2(SYNC + 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_STRETCH = 2'd2
    } state_t;

    logic [1:0]     rst_pipe_q;
    logic [WCW-1:0] warm_q;
    logic [NCH-1:0] sync_q [SYNC];
    logic [NCH-1:0] s_q;
    state_t         state_q [NCH];
    logic [CW-1:0]  cnt_q [NCH];
    logic [WW-1:0]  widm1_q [NCH];
    logic [NCH-1:0] retrig_q;
    logic [NCH-1:0] dout_q;
    logic [NCH-1:0] busy_q;
    logic [NCH-1:0] drop_q;
    logic           run;
    logic           warm;
    logic [NCH-1:0] edge_acc;

    // A width of 0 is treated as 1, so the stored count is max(wid,1)-1.
    function automatic logic [WW-1:0] wid_m1(input logic [WW-1:0] w);
        return (w == '0) ? '0 : w - 1'b1;
    endfunction

    assign run  = rst_pipe_q[1];
    // Edges are ignored until the synchroniser and its delayed copy hold real
    // post-reset samples; a level held high across reset must not look like an edge.
    assign warm = (warm_q == WCW'(SYNC + 1));

    always_comb begin
        edge_acc = sync_q[SYNC-1] & ~s_q & {NCH{warm}};
`ifdef DLY_VETO_EN
        edge_acc = edge_acc & ~{NCH{bus.veto}};
`endif
    end

    // Reset release pipeline, warm-up counter and input synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe_q <= '0;
            warm_q     <= '0;
            s_q        <= '0;
            for (int k = 0; k < SYNC; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            rst_pipe_q <= {rst_pipe_q[0], 1'b1};
            if (run && !warm) begin
                warm_q <= warm_q + 1'b1;
            end
            sync_q[0] <= bus.din;
            for (int k = 1; k < SYNC; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_q <= sync_q[SYNC-1];
        end
    end

    // Per-channel IDLE/DELAY/STRETCH machines with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                widm1_q[i] <= '0;
            end
            retrig_q <= '0;
            dout_q   <= '0;
            busy_q   <= '0;
            drop_q   <= '0;
        end else begin
            drop_q <= '0;
            if (run) begin
                for (int i = 0; i < NCH; i++) begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (edge_acc[i]) begin
                                // Configuration is frozen here for the whole pulse.
                                widm1_q[i]  <= wid_m1(bus.cfg_wid[i*WW +: WW]);
                                retrig_q[i] <= bus.cfg_retrig[i];
                                busy_q[i]   <= 1'b1;
                                if (bus.cfg_dly[i*DW +: DW] != '0) begin
                                    state_q[i] <= ST_DELAY;
                                    cnt_q[i]   <= CW'(bus.cfg_dly[i*DW +: DW] - 1'b1);
                                end else begin
                                    state_q[i] <= ST_STRETCH;
                                    cnt_q[i]   <= CW'(wid_m1(bus.cfg_wid[i*WW +: WW]));
                                    dout_q[i]  <= 1'b1;
                                end
                            end
                        end
                        ST_DELAY: begin
                            drop_q[i] <= edge_acc[i];
                            if (cnt_q[i] == '0) begin
                                state_q[i] <= ST_STRETCH;
                                cnt_q[i]   <= CW'(widm1_q[i]);
                                dout_q[i]  <= 1'b1;
                            end else begin
                                cnt_q[i] <= cnt_q[i] - 1'b1;
                            end
                        end
                        ST_STRETCH: begin
                            if (edge_acc[i] && retrig_q[i]) begin
                                cnt_q[i] <= CW'(widm1_q[i]);
                            end else begin
                                // A non-retriggerable edge, even on the last cycle,
                                // is reported and never starts a back-to-back pulse.
                                drop_q[i] <= edge_acc[i];
                                if (cnt_q[i] == '0) begin
                                    state_q[i] <= ST_IDLE;
                                    dout_q[i]  <= 1'b0;
                                    busy_q[i]  <= 1'b0;
                                end else begin
                                    cnt_q[i] <= cnt_q[i] - 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_q[i] <= ST_IDLE;
                            dout_q[i]  <= 1'b0;
                            busy_q[i]  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.drop = drop_q;
endmodule

// File: tb/tb_dly_stretch_bank.sv
// tb/tb_dly_stretch_bank.sv - self-checking bench for dly_stretch_bank
module tb_dly_stretch_bank;
    localparam int NCH  = 8;
    localparam int DW   = 4;
    localparam int WW   = 4;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dly_stretch_bank_if #(.NCH(NCH), .DW(DW), .WW(WW)) bus ();

    dly_stretch_bank #(.NCH(NCH), .DW(DW), .WW(WW), .SYNC(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: each channel is described by its accepted pulse as absolute
    // cycle numbers (busy from accept to m_end, dout from m_start to m_end).
    logic [NCH-1:0]    hist [SYNC+2];
    bit                m_act [NCH];
    bit                m_rt [NCH];
    int                m_start [NCH];
    int                m_end [NCH];
    int                m_w [NCH];
    logic [NCH-1:0]    samp, e_dout, e_busy, e_drop, prev_dout;
    logic [NCH*DW-1:0] c_dly;
    logic [NCH*WW-1:0] c_wid;
    logic [NCH-1:0]    c_rt;
    int                md, mw;

    int last_rise [NCH];
    int hi_total [NCH];
    int busy_total [NCH];
    int drop_total [NCH];
    int s_hi [NCH];
    int s_busy [NCH];
    int s_drop [NCH];
    int e;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: advances the model on every clock and compares all outputs.
    initial begin
        for (int k = 0; k < SYNC + 2; k++) hist[k] = '1;
        for (int i = 0; i < NCH; i++) begin
            m_act[i] = 1'b0; last_rise[i] = -1;
            hi_total[i] = 0; busy_total[i] = 0; drop_total[i] = 0;
        end
        prev_dout = '0;
        forever begin
            @(posedge clk);
            samp  = bus.din;
            c_dly = bus.cfg_dly;
            c_wid = bus.cfg_wid;
            c_rt  = bus.cfg_retrig;
            #1;
            cyc++;
            e_dout = '0; e_busy = '0; e_drop = '0;
            if (!rst_n) begin
                // After reset only a fresh low-to-high transition counts.
                for (int k = 0; k < SYNC + 2; k++) hist[k] = '1;
                for (int i = 0; i < NCH; i++) m_act[i] = 1'b0;
            end else begin
                for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = samp;
                for (int i = 0; i < NCH; i++) begin
                    md = int'(c_dly[i*DW +: DW]);
                    mw = int'(c_wid[i*WW +: WW]);
                    if (mw == 0) mw = 1;
                    if (m_act[i] && (cyc - 1 > m_end[i])) m_act[i] = 1'b0;
                    // Edge sampled SYNC clocks ago acts on this clock.
                    if (hist[SYNC][i] && !hist[SYNC+1][i]) begin
                        if (!m_act[i]) begin
                            m_act[i]   = 1'b1;
                            m_rt[i]    = c_rt[i];
                            m_w[i]     = mw;
                            m_start[i] = cyc + md;
                            m_end[i]   = cyc + md + mw - 1;
                        end else if (cyc - 1 < m_start[i]) begin
                            e_drop[i] = 1'b1;
                        end else if (m_rt[i]) begin
                            m_end[i] = cyc + m_w[i] - 1;
                        end else begin
                            e_drop[i] = 1'b1;
                        end
                    end
                    e_busy[i] = m_act[i] && (cyc <= m_end[i]);
                    e_dout[i] = m_act[i] && (cyc >= m_start[i]) && (cyc <= m_end[i]);
                end
            end
            check("model_dout", int'(bus.dout), int'(e_dout));
            check("model_busy", int'(bus.busy), int'(e_busy));
            check("model_drop", int'(bus.drop), int'(e_drop));
            for (int i = 0; i < NCH; i++) begin
                if (bus.dout[i] && !prev_dout[i]) last_rise[i] = cyc;
                if (bus.dout[i]) hi_total[i]++;
                if (bus.busy[i]) busy_total[i]++;
                if (bus.drop[i]) drop_total[i]++;
            end
            prev_dout = bus.dout;
        end
    end

    task automatic set_cfg(input int ch, input int d, input int w, input bit rt);
        bus.cfg_dly[ch*DW +: DW] = DW'(d);
        bus.cfg_wid[ch*WW +: WW] = WW'(w);
        bus.cfg_retrig[ch]       = rt;
    endtask

    task automatic snap();
        for (int i = 0; i < NCH; i++) begin
            s_hi[i] = hi_total[i]; s_busy[i] = busy_total[i]; s_drop[i] = drop_total[i];
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a 1,0,0,1,0 pattern on one channel: second edge lands on the clock
    // that starts the second STRETCH cycle of a dly=2 pulse.
    task automatic two_edges(input int ch);
        @(negedge clk); bus.din[ch] = 1'b1; e = cyc + 1;
        @(negedge clk); bus.din[ch] = 1'b0;
        ticks(2);       bus.din[ch] = 1'b1;
        @(negedge clk); bus.din[ch] = 1'b0;
    endtask

    initial begin
        bus.din = '0; bus.cfg_dly = '0; bus.cfg_wid = '0; bus.cfg_retrig = '0;
`ifdef DLY_VETO_EN
        bus.veto = 1'b0;
`endif
        rst_n = 1'b0;
        ticks(3);
        #1;
        check("reset_dout", int'(bus.dout), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_drop", int'(bus.drop), 0);
        @(negedge clk); rst_n = 1'b1;
        ticks(10);

        // ch0 dly=3 wid=2, input high for 5 samples.
        set_cfg(0, 3, 2, 1'b0);
        snap();
        @(negedge clk); bus.din[0] = 1'b1; e = cyc + 1;
        ticks(5); bus.din[0] = 1'b0;
        ticks(20);
        check("t1_rise", last_rise[0], e + 5);
        check("t1_width", hi_total[0] - s_hi[0], 2);
        check("t1_busy", busy_total[0] - s_busy[0], 5);
        check("t1_drop", drop_total[0] - s_drop[0], 0);

        // ch1 dly=0 wid=0, single-cycle input pulse.
        set_cfg(1, 0, 0, 1'b0);
        snap();
        @(negedge clk); bus.din[1] = 1'b1; e = cyc + 1;
        @(negedge clk); bus.din[1] = 1'b0;
        ticks(15);
        check("t2_rise", last_rise[1], e + 2);
        check("t2_width", hi_total[1] - s_hi[1], 1);

        // ch2 dly=2 wid=4, second edge in STRETCH, with and without retrigger.
        set_cfg(2, 2, 4, 1'b1);
        snap();
        two_edges(2);
        ticks(20);
        check("t3r_rise", last_rise[2], e + 4);
        check("t3r_width", hi_total[2] - s_hi[2], 5);
        check("t3r_drop", drop_total[2] - s_drop[2], 0);
        set_cfg(2, 2, 4, 1'b0);
        snap();
        two_edges(2);
        ticks(20);
        check("t3n_width", hi_total[2] - s_hi[2], 4);
        check("t3n_drop", drop_total[2] - s_drop[2], 1);

        // All channels at once, delay = channel index.
        for (int i = 0; i < NCH; i++) set_cfg(i, i, 2, 1'b0);
        @(negedge clk); bus.din = '1; e = cyc + 1;
        @(negedge clk); bus.din = '0;
        ticks(20);
        for (int i = 0; i < NCH; i++) check($sformatf("t4_rise_ch%0d", i), last_rise[i], e + 2 + i);

        // Reset in STRETCH with the input held high across release.
        set_cfg(3, 0, 15, 1'b0);
        @(negedge clk); bus.din[3] = 1'b1;
        ticks(5);
        rst_n = 1'b0;
        #1;
        check("t5_dout_async", int'(bus.dout), 0);
        check("t5_busy_async", int'(bus.busy), 0);
        ticks(3);
        rst_n = 1'b1;
        snap();
        ticks(30);
        check("t5_no_pulse", hi_total[3] - s_hi[3], 0);
        check("t5_no_busy", busy_total[3] - s_busy[3], 0);
        bus.din[3] = 1'b0;
        ticks(3);
        snap();
        bus.din[3] = 1'b1; e = cyc + 1;
        ticks(25);
        bus.din[3] = 1'b0;
        check("t5_new_rise", last_rise[3], e + 2);
        check("t5_new_width", hi_total[3] - s_hi[3], 15);
        ticks(5);

        // Random traffic and config churn against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            bus.din = bus.din ^ NCH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) begin
                bus.cfg_dly    = (NCH*DW)'($urandom);
                bus.cfg_wid    = (NCH*WW)'($urandom);
                bus.cfg_retrig = NCH'($urandom);
            end
        end
        bus.din = '0;
        ticks(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
